leaf_out_scheduler: RTL and testbench

//  Schedules the user-side output streams of one leaf onto the single leaf->BFT packet port.

---
 rtl/leaf_pkt_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/leaf_out_scheduler.sv | 178 +++++++++++++++++
 tb/tb_leaf_out_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// Packet field layout, pack helper and FSM state type shared by the leaf output scheduler.
package leaf_pkt_pkg;

  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_LEAF_BITS = 5;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;
  localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
  localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
  localparam int VLD_BIT     = LEAF_LSB + NUM_LEAF_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  function automatic logic [PACKET_BITS-1:0] pack_pkt(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    logic [PACKET_BITS-1:0] pkt;
    pkt = '0;
    pkt[VLD_BIT] = 1'b1;
    pkt[LEAF_LSB +: NUM_LEAF_BITS]   = leaf;
    pkt[PORT_LSB +: NUM_PORT_BITS]   = port;
    pkt[ADDR_LSB +: NUM_ADDR_BITS]   = addr;
    pkt[PAYLOAD_LSB +: PAYLOAD_BITS] = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after rr_ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(rr_ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/leaf_out_scheduler.sv
// Leaf output scheduler: round-robin, credit-gated merge of user streams onto the BFT packet port.
// Optional per-stream sent / stall counters are built when LEAF_OUT_SCHED_STATS_EN is defined.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no stream enabled yet, or just flushed; no grants
//   ST_RUN   | arbitrating enabled streams, one packet per cycle
//   ST_DRAIN | flush seen; wait for output register to empty, then reload
module leaf_out_scheduler
  import leaf_pkt_pkg::*;
#(
  parameter int  NUM_OUT_PORTS = 2,
  parameter int  CREDIT_BITS   = 8,
  parameter int  INIT_CREDITS  = 64,
  localparam int PW            = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
  input  logic                                  clk_bft,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic                                  cfg_we,
  input  logic [PW-1:0]                         cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
  input  logic                                  cfg_flush,
  input  logic                                  cr_vld,
  input  logic [PW-1:0]                         cr_port,
  input  logic [CREDIT_BITS-1:0]                cr_amt,
  output logic [PACKET_BITS-1:0]                pkt_out,
  input  logic                                  pkt_rdy,
  output logic                                  busy
`ifdef LEAF_OUT_SCHED_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*32-1:0]           stat_sent,
  output logic [31:0]                           stat_stall
`endif
);

  localparam int N = NUM_OUT_PORTS;
  localparam logic [CREDIT_BITS-1:0] CREDIT_FULL = CREDIT_BITS'(INIT_CREDITS);

  sched_state_t state, state_nxt;

  logic [N-1:0]             cfg_en, credit_nz, elig, gnt;
  logic [PW-1:0]            gnt_idx, rr_ptr;
  logic [NUM_LEAF_BITS-1:0] dst_leaf   [N];
  logic [NUM_PORT_BITS-1:0] dst_port   [N];
  logic [NUM_ADDR_BITS-1:0] addr       [N];
  logic [CREDIT_BITS-1:0]   credit     [N];
  logic [CREDIT_BITS:0]     credit_sum [N];
  logic [PAYLOAD_BITS-1:0]  payload    [N];
  logic [PACKET_BITS-1:0]   pkt_q;
  logic                     pkt_vld, load, clear_all;

  assign pkt_vld = pkt_q[VLD_BIT];
  assign pkt_out = pkt_q;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      payload[k]   = din_user[k*PAYLOAD_BITS +: PAYLOAD_BITS];
      credit_nz[k] = (credit[k] != '0);
    end
  end

  assign elig = vld_user & cfg_en & credit_nz;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req     (elig),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The flush cycle itself already blocks new grants.
  assign load     = (state == ST_RUN) && !cfg_flush && (|elig) && (!pkt_vld || pkt_rdy);
  assign ack_user = load ? gnt : '0;
  assign busy     = (state != ST_IDLE) || pkt_vld;

  always_comb begin
    state_nxt = state;
    clear_all = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_flush) clear_all = 1'b1;
        else if (|cfg_en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_flush) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pkt_vld) begin
          clear_all = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Return and consume on one stream net out before the saturation clamp.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      credit_sum[k] = {1'b0, credit[k]};
      if (cr_vld && (state != ST_DRAIN) && (cr_port == PW'(k)))
        credit_sum[k] = credit_sum[k] + {1'b0, cr_amt};
      if (ack_user[k])
        credit_sum[k] = credit_sum[k] - (CREDIT_BITS+1)'(1);
      if (credit_sum[k] > {1'b0, CREDIT_FULL})
        credit_sum[k] = {1'b0, CREDIT_FULL};
    end
  end

  always_ff @(posedge clk_bft or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cfg_en <= '0;
      rr_ptr <= '0;
      pkt_q  <= '0;
      for (int k = 0; k < N; k++) begin
        dst_leaf[k] <= '0;
        dst_port[k] <= '0;
        addr[k]     <= '0;
        credit[k]   <= CREDIT_FULL;
      end
    end else begin
      state <= state_nxt;
      if (load)
        pkt_q <= pack_pkt(dst_leaf[gnt_idx], dst_port[gnt_idx], addr[gnt_idx], payload[gnt_idx]);
      else if (pkt_rdy)
        pkt_q <= '0;
      if (cfg_we) begin
        dst_leaf[cfg_port] <= cfg_dst_leaf;
        dst_port[cfg_port] <= cfg_dst_port;
      end
      if (clear_all) begin
        cfg_en <= '0;
        for (int k = 0; k < N; k++) begin
          addr[k]   <= '0;
          credit[k] <= CREDIT_FULL;
        end
        if (state == ST_DRAIN) rr_ptr <= '0;
      end else begin
        if (cfg_we) cfg_en[cfg_port] <= 1'b1;
        for (int k = 0; k < N; k++) credit[k] <= credit_sum[k][CREDIT_BITS-1:0];
        if (load) begin
          addr[gnt_idx] <= addr[gnt_idx] + NUM_ADDR_BITS'(1);
          rr_ptr        <= (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
        end
      end
    end
  end

`ifdef LEAF_OUT_SCHED_STATS_EN
  logic [31:0] sent_cnt [N];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_bft or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      for (int k = 0; k < N; k++) sent_cnt[k] <= '0;
    end else if (clear_all) begin
      stall_cnt <= '0;
      for (int k = 0; k < N; k++) sent_cnt[k] <= '0;
    end else begin
      if (load) sent_cnt[gnt_idx] <= sent_cnt[gnt_idx] + 32'd1;
      if ((|elig) && !load) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) stat_sent[k*32 +: 32] = sent_cnt[k];
  end

  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_leaf_out_scheduler.sv
// Self-checking bench for leaf_out_scheduler: directed scenarios plus random traffic vs. a behavioural model.
module tb_leaf_out_scheduler;

  localparam int N = 2;

  logic          clk_bft = 1'b0;
  logic          reset_n;
  logic [N*32-1:0] din_user;
  logic [N-1:0]  vld_user;
  logic [N-1:0]  ack_user;
  logic          cfg_we;
  logic          cfg_port;
  logic [4:0]    cfg_dst_leaf;
  logic [3:0]    cfg_dst_port;
  logic          cfg_flush;
  logic          cr_vld;
  logic          cr_port;
  logic [7:0]    cr_amt;
  logic [48:0]   pkt_out;
  logic          pkt_rdy;
  logic          busy;
`ifdef LEAF_OUT_SCHED_STATS_EN
  logic [N*32-1:0] stat_sent;
  logic [31:0]     stat_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_bft = ~clk_bft;

  leaf_out_scheduler dut (
    .clk_bft      (clk_bft),
    .reset_n      (reset_n),
    .din_user     (din_user),
    .vld_user     (vld_user),
    .ack_user     (ack_user),
    .cfg_we       (cfg_we),
    .cfg_port     (cfg_port),
    .cfg_dst_leaf (cfg_dst_leaf),
    .cfg_dst_port (cfg_dst_port),
    .cfg_flush    (cfg_flush),
    .cr_vld       (cr_vld),
    .cr_port      (cr_port),
    .cr_amt       (cr_amt),
    .pkt_out      (pkt_out),
    .pkt_rdy      (pkt_rdy),
    .busy         (busy)
`ifdef LEAF_OUT_SCHED_STATS_EN
    ,
    .stat_sent    (stat_sent),
    .stat_stall   (stat_stall)
`endif
  );

  // Behavioural model: 0 = idle, 1 = running, 2 = draining.
  int          m_state;
  bit          m_en     [N];
  logic [4:0]  m_leaf   [N];
  logic [3:0]  m_port   [N];
  int          m_addr   [N];
  int          m_credit [N];
  int          m_rr;
  logic [48:0] m_pkt;
  bit          m_load;
  int          m_grant;
  logic [N-1:0] m_ack;
  bit          m_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_en[k]     = 1'b0;
      m_addr[k]   = 0;
      m_credit[k] = 64;
    end
  endtask

  task automatic model_reset();
    model_clear();
    for (int k = 0; k < N; k++) begin
      m_leaf[k] = '0;
      m_port[k] = '0;
    end
    m_state = 0;
    m_rr    = 0;
    m_pkt   = '0;
  endtask

  task automatic model_comb();
    m_load  = 1'b0;
    m_grant = 0;
    m_ack   = '0;
    if (m_state == 1 && !cfg_flush && (!m_pkt[48] || pkt_rdy)) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (!m_load && vld_user[k] && m_en[k] && m_credit[k] > 0) begin
          m_load  = 1'b1;
          m_grant = k;
        end
      end
    end
    if (m_load) m_ack[m_grant] = 1'b1;
    m_busy = (m_state != 0) || m_pkt[48];
  endtask

  task automatic model_edge();
    bit old_vld;
    bit any_en;
    old_vld = m_pkt[48];
    any_en  = 1'b0;
    for (int k = 0; k < N; k++) any_en |= m_en[k];
    for (int k = 0; k < N; k++) begin
      int c;
      c = m_credit[k];
      if (cr_vld && m_state != 2 && int'(cr_port) == k) c += int'(cr_amt);
      if (m_load && m_grant == k) c -= 1;
      if (c > 64) c = 64;
      m_credit[k] = c;
    end
    if (m_load) begin
      m_pkt = {1'b1, m_leaf[m_grant], m_port[m_grant], 7'(m_addr[m_grant]),
               din_user[m_grant*32 +: 32]};
      m_addr[m_grant] = (m_addr[m_grant] + 1) % 128;
      m_rr = (m_grant + 1) % N;
    end else if (pkt_rdy) begin
      m_pkt = '0;
    end
    if (cfg_we) begin
      m_leaf[cfg_port] = cfg_dst_leaf;
      m_port[cfg_port] = cfg_dst_port;
      m_en[cfg_port]   = 1'b1;
    end
    case (m_state)
      0: begin
        if (cfg_flush) model_clear();
        else if (any_en) m_state = 1;
      end
      1: if (cfg_flush) m_state = 2;
      default: begin
        if (!old_vld) begin
          model_clear();
          m_rr    = 0;
          m_state = 0;
        end
      end
    endcase
  endtask

  // One clock: inputs already set; check mid-cycle, advance model on the edge.
  task automatic step();
    @(negedge clk_bft);
    #1;
    model_comb();
    check("ack", {62'd0, ack_user}, {62'd0, m_ack});
    check("pkt", {15'd0, pkt_out}, {15'd0, m_pkt});
    check("busy", {63'd0, busy}, {63'd0, m_busy});
    @(posedge clk_bft);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic cfg_write(input logic p, input logic [4:0] leaf, input logic [3:0] port);
    cfg_we = 1'b1; cfg_port = p; cfg_dst_leaf = leaf; cfg_dst_port = port;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int acks;
    logic [48:0] cap;

    reset_n = 1'b0;
    din_user = '0; vld_user = '0; cfg_we = 1'b0; cfg_port = 1'b0;
    cfg_dst_leaf = '0; cfg_dst_port = '0; cfg_flush = 1'b0;
    cr_vld = 1'b0; cr_port = 1'b0; cr_amt = '0; pkt_rdy = 1'b1;
    model_reset();
    repeat (3) step();
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset_n = 1'b1;
    step();

    // T1: single word on s0
    cfg_write(1'b0, 5'd3, 4'd2);
    cfg_write(1'b1, 5'd7, 4'd9);
    step();
    vld_user = 2'b01; din_user[31:0] = 32'hDEADBEEF;
    #1 check("t1_ack", {62'd0, ack_user}, 64'd1);
    step();
    vld_user = 2'b00;
    check("t1_pkt", {15'd0, pkt_out}, {15'd0, 1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});

    // T2: both streams alternate
    vld_user = 2'b11;
    for (int i = 0; i < 8; i++) begin
      din_user = {$urandom, $urandom};
      #1 check("t2_alt", {62'd0, ack_user}, (i % 2 == 0) ? 64'd2 : 64'd1);
      step();
    end
    vld_user = 2'b00;

    // T3: flush to reload, then exhaust s0 credits
    cfg_flush = 1'b1; step(); cfg_flush = 1'b0;
    for (int i = 0; i < 20 && m_state != 0; i++) step();
    check("t3_idle", {63'd0, busy}, 64'd0);
    cfg_write(1'b0, 5'd1, 4'd1);
    cfg_write(1'b1, 5'd2, 4'd5);
    step();
    vld_user = 2'b01; acks = 0;
    for (int i = 0; i < 70; i++) begin
      din_user = {$urandom, $urandom};
      #1 acks += int'(ack_user[0]);
      step();
    end
    check("t3_acks", 64'(acks), 64'd64);
    cr_vld = 1'b1; cr_port = 1'b0; cr_amt = 8'd4; step(); cr_vld = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      #1 acks += int'(ack_user[0]);
      step();
    end
    check("t3_ret", 64'(acks), 64'd4);

    // T4: backpressure on s1
    vld_user = 2'b10; pkt_rdy = 1'b1; step();
    cap = pkt_out;
    pkt_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("t4_ack", {62'd0, ack_user}, 64'd0);
      step();
      check("t4_hold", {15'd0, pkt_out}, {15'd0, cap});
    end
    pkt_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_resume", {62'd0, ack_user}, 64'd2);
      step();
    end
    vld_user = 2'b00;

    // T5: address wrap on s0
    cr_vld = 1'b1; cr_port = 1'b0; cr_amt = 8'd64; step(); cr_vld = 1'b0;
    vld_user = 2'b01;
    for (int i = 0; i < 200 && m_addr[0] != 127; i++) step();
    step();
    check("t5_a127", 64'(pkt_out[38:32]), 64'd127);
    step();
    check("t5_a0", 64'(pkt_out[38:32]), 64'd0);

    // T6: flush with output stalled
    step();
    pkt_rdy = 1'b0; cfg_flush = 1'b1;
    #1 check("t6_ack0", {62'd0, ack_user}, 64'd0);
    step();
    cfg_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("t6_ack_drain", {62'd0, ack_user}, 64'd0);
      step();
    end
    check("t6_busy_hold", {63'd0, busy}, 64'd1);
    pkt_rdy = 1'b1;
    step(); step();
    check("t6_idle", {63'd0, busy}, 64'd0);
    vld_user = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1 check("t6_noen", {62'd0, ack_user}, 64'd0);
      step();
    end
    vld_user = 2'b00;
    cfg_write(1'b0, 5'd4, 4'd4);
    step();
    vld_user = 2'b01; acks = 0;
    for (int i = 0; i < 66; i++) begin
      #1 acks += int'(ack_user[0]);
      step();
    end
    check("t6_credits", 64'(acks), 64'd64);
    vld_user = 2'b00;

    // Async reset with a packet held in the output register
    cfg_write(1'b1, 5'd9, 4'd3);
    vld_user = 2'b10; pkt_rdy = 1'b0;
    for (int i = 0; i < 10 && !m_pkt[48]; i++) step();
    @(negedge clk_bft);
    #2 reset_n = 1'b0;
    #1;
    check("arst_pkt", {15'd0, pkt_out}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    model_reset();
    vld_user = 2'b00; pkt_rdy = 1'b1;
    @(posedge clk_bft);
    #1 reset_n = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      din_user     = {$urandom, $urandom};
      vld_user     = 2'($urandom);
      pkt_rdy      = ($urandom_range(0, 3) != 0);
      cr_vld       = ($urandom_range(0, 15) == 0);
      cr_port      = 1'($urandom);
      cr_amt       = 8'($urandom_range(0, 12));
      cfg_we       = ($urandom_range(0, 24) == 0);
      cfg_port     = 1'($urandom);
      cfg_dst_leaf = 5'($urandom);
      cfg_dst_port = 4'($urandom);
      cfg_flush    = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
